// File: rtl/compat_trig_collector_pkg.sv
// Shared definitions for the 40 MHz compatibility-mode trigger collector:
// state encoding, TRIG_IN source indices and default widths.
package compat_trig_collector_pkg;

    localparam int COINC_BITS_DFLT   = 3;
    localparam int HOLDOFF_BITS_DFLT = 16;
    localparam int CNT_BITS_DFLT     = 32;

    localparam int NUM_SRC  = 5;
    localparam int SRC_SB   = 0;
    localparam int SRC_TOT  = 1;
    localparam int SRC_TOTD = 2;
    localparam int SRC_MOPS = 3;
    localparam int SRC_EXT  = 4;

    // 40 MHz tick logic advances on the cycle where the registered phase equals this.
    localparam logic [1:0] STROBE_PHASE = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COINC    = 3'd1,
        ST_FIRE     = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_HOLDOFF  = 3'd4
    } state_t;

endpackage

// File: rtl/compat_trig_collector_if.sv
// Readout handshake between the trigger collector (master) and the
// event buffer manager (slave).
interface compat_trig_collector_if #(
    parameter int CNT_BITS = compat_trig_collector_pkg::CNT_BITS_DFLT
);
    import compat_trig_collector_pkg::*;

    logic                BUF_FULL;
    logic                ACK;
    logic                TRIG_OUT;
    logic [NUM_SRC-1:0]  TRIG_TYPE;
    logic                TRIG_PENDING;
    logic [CNT_BITS-1:0] ACCEPTED_CNT;

    modport master (
        input  BUF_FULL, ACK,
        output TRIG_OUT, TRIG_TYPE, TRIG_PENDING, ACCEPTED_CNT
    );

    modport slave (
        output BUF_FULL, ACK,
        input  TRIG_OUT, TRIG_TYPE, TRIG_PENDING, ACCEPTED_CNT
    );

endinterface

// File: rtl/compat_trig_edge.sv
// Strobe-gated rising-edge detector and source mask; new_evt is only
// non-zero on strobe cycles.
module compat_trig_edge
    import compat_trig_collector_pkg::*;
(
    input  logic               CLK120,
    input  logic               RST_N,
    input  logic               strobe,
    input  logic [NUM_SRC-1:0] trig_in,
    input  logic [NUM_SRC-1:0] trig_mask,
    output logic [NUM_SRC-1:0] new_evt
);

    logic [NUM_SRC-1:0] prev_q;

    always_ff @(posedge CLK120 or negedge RST_N) begin
        if (!RST_N) begin
            prev_q <= '0;
        end else if (strobe) begin
            prev_q <= trig_in;
        end
    end

    assign new_evt = strobe ? (trig_in & ~prev_q & trig_mask) : '0;

endmodule

// File: rtl/compat_trig_collector.sv
// Collects 40 MHz compatibility triggers into one typed trigger pulse with
// ACK handshake and holdoff. Optional LOST_CNT output: COMPAT_TRIG_LOST_CNT_EN.
//
// state       | meaning
// ST_IDLE     | armed, waiting for a new edge
// ST_COINC    | gathering coincident sources for COINC_WIN ticks
// ST_FIRE     | one-cycle trigger pulse
// ST_WAIT_ACK | trigger pending until readout ACK
// ST_HOLDOFF  | dead time of HOLDOFF ticks after ACK
module compat_trig_collector
    import compat_trig_collector_pkg::*;
#(
    parameter int COINC_BITS   = COINC_BITS_DFLT,
    parameter int HOLDOFF_BITS = HOLDOFF_BITS_DFLT,
    parameter int CNT_BITS     = CNT_BITS_DFLT
) (
    input  logic                    CLK120,
    input  logic                    RST_N,
    input  logic [1:0]              ENABLE40,
    input  logic [NUM_SRC-1:0]      TRIG_IN,
    input  logic [NUM_SRC-1:0]      TRIG_MASK,
    input  logic [COINC_BITS-1:0]   COINC_WIN,
    input  logic [HOLDOFF_BITS-1:0] HOLDOFF,
`ifdef COMPAT_TRIG_LOST_CNT_EN
    output logic [15:0]             LOST_CNT,
`endif
    compat_trig_collector_if.master rd
);

    logic [1:0]              lcl_enable40;
    logic                    strobe;
    logic [NUM_SRC-1:0]      new_evt;
    logic                    evt_any;
    state_t                  state_q, state_d;
    logic [NUM_SRC-1:0]      type_acc_q, type_acc_d;
    logic [COINC_BITS-1:0]   ccnt_q, ccnt_d;
    logic [HOLDOFF_BITS-1:0] hcnt_q, hcnt_d;
    logic                    fire_d, pending_d;
    logic                    trig_out_q, pending_q;
    logic [NUM_SRC-1:0]      trig_type_q;
    logic [CNT_BITS-1:0]     accepted_q;

    assign strobe  = (lcl_enable40 == STROBE_PHASE);
    assign evt_any = |new_evt;

    compat_trig_edge u_edge (
        .CLK120    (CLK120),
        .RST_N     (RST_N),
        .strobe    (strobe),
        .trig_in   (TRIG_IN),
        .trig_mask (TRIG_MASK),
        .new_evt   (new_evt)
    );

    always_ff @(posedge CLK120 or negedge RST_N) begin
        if (!RST_N) begin
            lcl_enable40 <= '0;
            state_q      <= ST_IDLE;
            type_acc_q   <= '0;
            ccnt_q       <= '0;
            hcnt_q       <= '0;
            trig_out_q   <= 1'b0;
            pending_q    <= 1'b0;
            trig_type_q  <= '0;
            accepted_q   <= '0;
        end else begin
            lcl_enable40 <= ENABLE40;
            state_q      <= state_d;
            type_acc_q   <= type_acc_d;
            ccnt_q       <= ccnt_d;
            hcnt_q       <= hcnt_d;
            trig_out_q   <= fire_d;
            pending_q    <= pending_d;
            if (fire_d) begin
                trig_type_q <= type_acc_d;
                accepted_q  <= accepted_q + CNT_BITS'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        type_acc_d = type_acc_q;
        ccnt_d     = ccnt_q;
        hcnt_d     = hcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (evt_any && !rd.BUF_FULL) begin
                    type_acc_d = new_evt;
                    ccnt_d     = COINC_WIN;
                    state_d    = (COINC_WIN == '0) ? ST_FIRE : ST_COINC;
                end
            end
            ST_COINC: begin
                if (strobe) begin
                    type_acc_d = type_acc_q | new_evt;
                    ccnt_d     = ccnt_q - COINC_BITS'(1);
                    if (ccnt_q <= COINC_BITS'(1)) state_d = ST_FIRE;
                end
            end
            ST_FIRE: state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (rd.ACK) begin
                    hcnt_d  = HOLDOFF;
                    state_d = (HOLDOFF == '0) ? ST_IDLE : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (strobe) begin
                    hcnt_d = hcnt_q - HOLDOFF_BITS'(1);
                    if (hcnt_q <= HOLDOFF_BITS'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        fire_d    = (state_d == ST_FIRE);
        pending_d = (state_d == ST_WAIT_ACK);
    end

    assign rd.TRIG_OUT     = trig_out_q;
    assign rd.TRIG_TYPE    = trig_type_q;
    assign rd.TRIG_PENDING = pending_q;
    assign rd.ACCEPTED_CNT = accepted_q;

`ifdef COMPAT_TRIG_LOST_CNT_EN
    logic        evt_lost;
    logic [15:0] lost_q;

    always_comb begin
        evt_lost = evt_any && ((state_q == ST_IDLE && rd.BUF_FULL) ||
                               state_q == ST_WAIT_ACK || state_q == ST_HOLDOFF);
    end

    always_ff @(posedge CLK120 or negedge RST_N) begin
        if (!RST_N) begin
            lost_q <= '0;
        end else if (evt_lost && lost_q != 16'hFFFF) begin
            lost_q <= lost_q + 16'd1;
        end
    end

    assign LOST_CNT = lost_q;
`endif

endmodule

// File: tb/tb_compat_trig_collector.sv
// Self-checking bench for compat_trig_collector: table vectors, directed
// corner sequences and a randomized run against a timestamp-based model.
module tb_compat_trig_collector;
    import compat_trig_collector_pkg::*;

    logic        CLK120 = 1'b0;
    logic        RST_N  = 1'b1;
    logic [1:0]  enable40 = 2'd0;
    logic [4:0]  trig_in = '0;
    logic [4:0]  trig_mask = 5'h1f;
    logic [2:0]  coinc_win = '0;
    logic [15:0] holdoff = '0;
`ifdef COMPAT_TRIG_LOST_CNT_EN
    logic [15:0] lost_cnt;
`endif

    compat_trig_collector_if #(.CNT_BITS(32)) rd();

    compat_trig_collector #(.COINC_BITS(3), .HOLDOFF_BITS(16), .CNT_BITS(32)) dut (
        .CLK120    (CLK120),
        .RST_N     (RST_N),
        .ENABLE40  (enable40),
        .TRIG_IN   (trig_in),
        .TRIG_MASK (trig_mask),
        .COINC_WIN (coinc_win),
        .HOLDOFF   (holdoff),
`ifdef COMPAT_TRIG_LOST_CNT_EN
        .LOST_CNT  (lost_cnt),
`endif
        .rd        (rd)
    );

    always #5 CLK120 = ~CLK120;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    int pulse_total = 0;
    int w_first, w_pulses, p0;
    logic [4:0] w_type;
    longint exp_cnt = 0;
    int exp_lost = 0;

    always @(negedge CLK120) if (rd.TRIG_OUT === 1'b1) pulse_total++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; S-cycles are cyc%3==2.
    task automatic step();
        @(posedge CLK120);
        #1;
        cyc++;
        enable40 = 2'(cyc % 3);
    endtask

    task automatic wait_s();
        step();
        while (cyc % 3 != 2) step();
    endtask

    task automatic watch(input int n);
        w_first  = -1;
        w_pulses = 0;
        for (int i = 0; i < n; i++) begin
            if (rd.TRIG_OUT === 1'b1) begin
                w_pulses++;
                if (w_first < 0) w_first = cyc - t0;
                w_type = rd.TRIG_TYPE;
            end
            step();
        end
    endtask

    task automatic ack_pulse();
        rd.ACK = 1'b1;
        step();
        rd.ACK = 1'b0;
        step();
    endtask

    task automatic do_reset();
        trig_in = '0;
        rd.ACK = 1'b0;
        rd.BUF_FULL = 1'b0;
        RST_N = 1'b0;
        step();
        step();
        RST_N = 1'b1;
        step();
        step();
        exp_cnt  = 0;
        exp_lost = 0;
    endtask

    // Reference model: trigger lifetime tracked with absolute cycle stamps.
    bit         busy, acked;
    int         fire_at, free_from;
    logic [4:0] m_prev, m_acc, e_type;
    bit         e_out, e_pend;
    longint     e_cnt;
    int         e_lost;

    task automatic model_cycle(input int c, input logic [4:0] t, input logic [4:0] m,
                               input int k, input int h, input bit bf, input bit ak);
        logic [4:0] nv;
        int s1;
        nv = (c % 3 == 2) ? (t & ~m_prev & m) : 5'd0;
        if (c % 3 == 2) m_prev = t;
        if (busy && acked && c >= free_from) busy = 0;
        if (!busy) begin
            if (nv != 0) begin
                if (bf) begin
                    if (e_lost < 65535) e_lost++;
                end else begin
                    busy = 1;
                    acked = 0;
                    fire_at = c + 3 * k + 1;
                    m_acc = nv;
                end
            end
        end else if (c < fire_at) begin
            m_acc |= nv;
        end else if (c > fire_at) begin
            if (nv != 0 && e_lost < 65535) e_lost++;
            if (!acked && ak) begin
                acked = 1;
                s1 = c + 1;
                while (s1 % 3 != 2) s1++;
                free_from = (h == 0) ? c + 1 : s1 + 3 * (h - 1) + 1;
            end
        end
        e_out = busy && (c + 1 == fire_at);
        if (e_out) begin
            e_type = m_acc;
            e_cnt++;
        end
        e_pend = busy && !acked && (c + 1 > fire_at);
    endtask

    typedef struct {
        int         src;
        logic [4:0] mask;
        int         k;
        int         lat;
        logic [4:0] typ;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{SRC_TOTD, 5'h1f,    0,  1, 5'b00100};
        vecs[1] = '{SRC_SB,   5'h1f,    1,  4, 5'b00001};
        vecs[2] = '{SRC_EXT,  5'h1f,    3, 10, 5'b10000};
        vecs[3] = '{SRC_MOPS, 5'b10111, 0, -1, 5'b00000};
        vecs[4] = '{SRC_TOT,  5'h1f,    7, 22, 5'b00010};

        rd.ACK = 1'b0;
        rd.BUF_FULL = 1'b0;
        step();

        // Reset values, checked while reset is held.
        RST_N = 1'b0;
        #1;
        check("reset trig_out", rd.TRIG_OUT, 0);
        check("reset trig_type", rd.TRIG_TYPE, 0);
        check("reset pending", rd.TRIG_PENDING, 0);
        check("reset accepted_cnt", rd.ACCEPTED_CNT, 0);
`ifdef COMPAT_TRIG_LOST_CNT_EN
        check("reset lost_cnt", lost_cnt, 0);
`endif
        do_reset();

        // BUF_FULL drops three TOTD edges.
        rd.BUF_FULL = 1'b1;
        p0 = pulse_total;
        for (int i = 0; i < 3; i++) begin
            wait_s();
            trig_in = 5'b00100;
            step();
            trig_in = '0;
            wait_s();
        end
        step();
        rd.BUF_FULL = 1'b0;
        exp_lost = 3;
        check("buf_full pulses", pulse_total - p0, 0);
        check("buf_full accepted_cnt", rd.ACCEPTED_CNT, 0);
        check("buf_full pending", rd.TRIG_PENDING, 0);
`ifdef COMPAT_TRIG_LOST_CNT_EN
        check("buf_full lost_cnt", lost_cnt, exp_lost);
`endif

        // Single-source latency/type table, HOLDOFF = 0.
        for (int v = 0; v < 5; v++) begin
            trig_mask = vecs[v].mask;
            coinc_win = 3'(vecs[v].k);
            holdoff   = '0;
            wait_s();
            trig_in = 5'(1 << vecs[v].src);
            t0 = cyc;
            step();
            trig_in = '0;
            watch(40);
            check($sformatf("vec%0d latency", v), w_first, vecs[v].lat);
            check($sformatf("vec%0d pulses", v), w_pulses, (vecs[v].lat >= 0) ? 1 : 0);
            if (vecs[v].lat >= 0) begin
                exp_cnt++;
                check($sformatf("vec%0d trig_type", v), w_type, vecs[v].typ);
            end
            check($sformatf("vec%0d accepted_cnt", v), rd.ACCEPTED_CNT, exp_cnt);
            check($sformatf("vec%0d pending", v), rd.TRIG_PENDING, (vecs[v].lat >= 0) ? 1 : 0);
            ack_pulse();
            check($sformatf("vec%0d pending after ack", v), rd.TRIG_PENDING, 0);
        end
        trig_mask = 5'h1f;

        // Coincidence: SB then TOT one tick later inside a 2-tick window.
        coinc_win = 3'd2;
        wait_s();
        trig_in = 5'b00001;
        t0 = cyc;
        step();
        trig_in = '0;
        wait_s();
        trig_in = 5'b00010;
        step();
        trig_in = '0;
        watch(20);
        exp_cnt++;
        check("coinc latency", w_first, 7);
        check("coinc pulses", w_pulses, 1);
        check("coinc trig_type", w_type, 5'b00011);
        check("coinc accepted_cnt", rd.ACCEPTED_CNT, exp_cnt);
        ack_pulse();

        // Level held for 50 ticks with ACK tied high fires once.
        coinc_win = '0;
        rd.ACK = 1'b1;
        wait_s();
        trig_in = 5'b00001;
        t0 = cyc;
        step();
        watch(150);
        trig_in = '0;
        rd.ACK = 1'b0;
        exp_cnt++;
        check("level pulses", w_pulses, 1);
        check("level accepted_cnt", rd.ACCEPTED_CNT, exp_cnt);
        step();
        check("level pending", rd.TRIG_PENDING, 0);

        // Holdoff of 10 ticks: edge at tick 5 lost, edge at tick 12 accepted.
        holdoff = 16'd10;
        wait_s();
        trig_in = 5'b10000;
        t0 = cyc;
        step();
        trig_in = '0;
        check("holdoff first fire", rd.TRIG_OUT, 1);
        exp_cnt++;
        step();
        rd.ACK = 1'b1;
        step();
        rd.ACK = 1'b0;
        for (int i = 0; i < 4; i++) wait_s();
        trig_in = 5'b10000;
        p0 = pulse_total;
        step();
        trig_in = '0;
        exp_lost++;
        for (int i = 0; i < 7; i++) wait_s();
        check("holdoff early edge ignored", pulse_total - p0, 0);
`ifdef COMPAT_TRIG_LOST_CNT_EN
        check("holdoff lost_cnt", lost_cnt, exp_lost);
`endif
        trig_in = 5'b10000;
        t0 = cyc;
        step();
        trig_in = '0;
        watch(5);
        exp_cnt++;
        check("holdoff late edge latency", w_first, 1);
        check("holdoff accepted_cnt", rd.ACCEPTED_CNT, exp_cnt);
        holdoff = '0;
        ack_pulse();

        // Reset while collecting drops the event.
        coinc_win = 3'd5;
        wait_s();
        trig_in = 5'b00001;
        step();
        trig_in = '0;
        step();
        step();
        p0 = pulse_total;
        RST_N = 1'b0;
        #1;
        check("midreset trig_out", rd.TRIG_OUT, 0);
        check("midreset trig_type", rd.TRIG_TYPE, 0);
        check("midreset pending", rd.TRIG_PENDING, 0);
        check("midreset accepted_cnt", rd.ACCEPTED_CNT, 0);
        step();
        RST_N = 1'b1;
        exp_cnt = 0;
        exp_lost = 0;
        for (int i = 0; i < 30; i++) step();
        check("midreset no pulse", pulse_total - p0, 0);
        coinc_win = '0;
        wait_s();
        trig_in = 5'b00100;
        t0 = cyc;
        step();
        trig_in = '0;
        watch(5);
        exp_cnt++;
        check("post-reset latency", w_first, 1);
        check("post-reset trig_type", w_type, 5'b00100);
        check("post-reset accepted_cnt", rd.ACCEPTED_CNT, exp_cnt);
        ack_pulse();

        // Randomized run against the reference model.
        do_reset();
        busy = 0; acked = 0; fire_at = 0; free_from = 0;
        m_prev = '0; m_acc = '0; e_type = '0;
        e_out = 0; e_pend = 0; e_cnt = 0; e_lost = 0;
        for (int n = 0; n < 1200; n++) begin
            check("rnd trig_out", rd.TRIG_OUT, e_out);
            check("rnd pending", rd.TRIG_PENDING, e_pend);
            check("rnd trig_type", rd.TRIG_TYPE, e_type);
            check("rnd accepted_cnt", rd.ACCEPTED_CNT, e_cnt);
`ifdef COMPAT_TRIG_LOST_CNT_EN
            check("rnd lost_cnt", lost_cnt, e_lost);
`endif
            trig_in     = 5'($urandom & $urandom);
            trig_mask   = ($urandom_range(0, 5) == 0) ? ~(5'(1 << $urandom_range(0, 4))) : 5'h1f;
            coinc_win   = 3'($urandom_range(0, 3));
            holdoff     = 16'($urandom_range(0, 3));
            rd.BUF_FULL = ($urandom_range(0, 9) == 0);
            rd.ACK      = ($urandom_range(0, 3) == 0);
            model_cycle(cyc, trig_in, trig_mask, int'(coinc_win), int'(holdoff),
                        rd.BUF_FULL, rd.ACK);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
